// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational field decode and regfile read enables,
// registered operands/immediate/control toward EX, load-use stall, flush and perf counters.
module decode_stage #(
  parameter int XLEN          = 32,
  parameter int PC_WIDTH      = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [PC_WIDTH-1:0]      pc_i,
  input  logic [31:0]              instr_i,
  output logic [REG_IDX_WIDTH-1:0] rs1_idx_o,
  output logic [REG_IDX_WIDTH-1:0] rs2_idx_o,
  output logic                     rs1_en_o,
  output logic                     rs2_en_o,
  input  logic [XLEN-1:0]          rs1_rdata_i,
  input  logic [XLEN-1:0]          rs2_rdata_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [PC_WIDTH-1:0]      dec_pc_o,
  output logic [31:0]              dec_instr_o,
  output logic [XLEN-1:0]          dec_rs1_rdata_o,
  output logic [XLEN-1:0]          dec_rs2_rdata_o,
  output logic [XLEN-1:0]          dec_imm_o,
  output logic [REG_IDX_WIDTH-1:0] dec_rd_idx_o,
  output logic                     dec_rd_en_o,
  output logic                     dec_illegal_o,
  output logic [CNT_WIDTH-1:0]     instr_cnt_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] zext_zimm(input logic [4:0] z);
    return XLEN'(z);
  endfunction

  logic [6:0] opcode;
  logic [2:0] fun3;
  assign opcode = instr_i[6:0];
  assign fun3   = instr_i[14:12];

  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_j32, imm_u32;
  assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u32 = {instr_i[31:12], 12'b0};

  logic                   rs1_en, rs2_en, rd_en_d, illegal_d, load_d;
  logic signed [XLEN-1:0] imm_d;

  always_comb begin
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    rd_en_d   = 1'b0;
    illegal_d = 1'b0;
    imm_d     = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        rs1_en  = 1'b1;
        rd_en_d = 1'b1;
        imm_d   = sext_xlen(imm_i32);
      end
      OPC_OP: begin
        rs1_en  = 1'b1;
        rs2_en  = 1'b1;
        rd_en_d = 1'b1;
      end
      OPC_STORE: begin
        rs1_en = 1'b1;
        rs2_en = 1'b1;
        imm_d  = sext_xlen(imm_s32);
      end
      OPC_BRANCH: begin
        rs1_en = 1'b1;
        rs2_en = 1'b1;
        imm_d  = sext_xlen(imm_b32);
      end
      OPC_JAL: begin
        rd_en_d = 1'b1;
        imm_d   = sext_xlen(imm_j32);
      end
      OPC_LUI, OPC_AUIPC: begin
        rd_en_d = 1'b1;
        imm_d   = sext_xlen(imm_u32);
      end
      OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
        // fun3=000 is ECALL/EBREAK/xRET; 100 is unassigned; others are CSR ops
        if (fun3 == 3'b100) begin
          illegal_d = 1'b1;
        end else if (fun3 != 3'b000) begin
          rd_en_d = 1'b1;
          if (fun3[2]) imm_d = zext_zimm(instr_i[19:15]);
          else         rs1_en = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) illegal_d = 1'b1;
    if (illegal_d) begin
      rs1_en  = 1'b0;
      rs2_en  = 1'b0;
      rd_en_d = 1'b0;
      imm_d   = '0;
    end
  end

  assign load_d    = (opcode == OPC_LOAD) && !illegal_d;
  assign rs1_idx_o = REG_IDX_WIDTH'(instr_i[19:15]);
  assign rs2_idx_o = REG_IDX_WIDTH'(instr_i[24:20]);
  assign rs1_en_o  = rs1_en;
  assign rs2_en_o  = rs2_en;

  logic                     dec_valid_q, load_q, rd_en_q, illegal_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [31:0]              instr_q;
  logic [XLEN-1:0]          rs1_q, rs2_q;
  logic signed [XLEN-1:0]   imm_q;
  logic [REG_IDX_WIDTH-1:0] rd_q;
  logic [CNT_WIDTH-1:0]     instr_cnt_q, stall_cnt_q;
  logic [CNT_WIDTH-1:0]     instr_cnt_d, stall_cnt_d;
  logic                     valid_d, hazard, accept;

  // Held load whose rd feeds an enabled source of the incoming instruction
  assign hazard = dec_valid_q && load_q && (rd_q != '0) &&
                  ((rs1_en && (rs1_idx_o == rd_q)) || (rs2_en && (rs2_idx_o == rd_q)));
  assign if_ready_o = (!dec_valid_q || dec_ready_i) && !hazard;
  assign accept     = if_valid_i && if_ready_o && !flush_i;

  always_comb begin
    valid_d = dec_valid_q;
    if (flush_i)          valid_d = 1'b0;
    else if (accept)      valid_d = 1'b1;
    else if (dec_ready_i) valid_d = 1'b0;
    instr_cnt_d = instr_cnt_q + CNT_WIDTH'(dec_valid_q && dec_ready_i);
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(if_valid_i && hazard && !flush_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      load_q      <= 1'b0;
      pc_q        <= '0;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      dec_valid_q <= valid_d;
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) begin
        load_q    <= load_d;
        pc_q      <= pc_i;
        instr_q   <= instr_i;
        rs1_q     <= rs1_rdata_i;
        rs2_q     <= rs2_rdata_i;
        imm_q     <= imm_d;
        rd_q      <= REG_IDX_WIDTH'(instr_i[11:7]);
        rd_en_q   <= rd_en_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign dec_valid_o     = dec_valid_q;
  assign dec_pc_o        = pc_q;
  assign dec_instr_o     = instr_q;
  assign dec_rs1_rdata_o = rs1_q;
  assign dec_rs2_rdata_o = rs2_q;
  assign dec_imm_o       = imm_q;
  assign dec_rd_idx_o    = rd_q;
  assign dec_rd_en_o     = rd_en_q;
  assign dec_illegal_o   = illegal_q;
  assign instr_cnt_o     = instr_cnt_q;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a
// behavioural model of the decode rules and the handshake/hazard pipeline.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, if_valid, dec_ready;
  logic [31:0] pc, instr, rs1d, rs2d;
  logic        if_ready, rs1_en, rs2_en, dec_valid, dec_rd_en, dec_ill;
  logic [4:0]  rs1_idx, rs2_idx, dec_rd;
  logic [31:0] dec_pc, dec_instr, dec_rs1, dec_rs2, dec_imm, icnt, scnt;

  logic        f64, v64, rdy64;
  logic [31:0] pc64, instr64;
  logic [63:0] rs1d64, rs2d64;
  logic        if_ready64, rs1_en64, rs2_en64, dec_valid64, dec_rd_en64, dec_ill64;
  logic [4:0]  rs1_idx64, rs2_idx64, dec_rd64;
  logic [31:0] dec_pc64, dec_instr64, icnt64, scnt64;
  logic [63:0] dec_rs1_64, dec_rs2_64, dec_imm64;

  int n_pass = 0;
  int n_total = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready),
    .pc_i(pc), .instr_i(instr), .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx),
    .rs1_en_o(rs1_en), .rs2_en_o(rs2_en), .rs1_rdata_i(rs1d), .rs2_rdata_i(rs2d),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .dec_pc_o(dec_pc),
    .dec_instr_o(dec_instr), .dec_rs1_rdata_o(dec_rs1), .dec_rs2_rdata_o(dec_rs2),
    .dec_imm_o(dec_imm), .dec_rd_idx_o(dec_rd), .dec_rd_en_o(dec_rd_en),
    .dec_illegal_o(dec_ill), .instr_cnt_o(icnt), .stall_cnt_o(scnt)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush_i(f64), .if_valid_i(v64), .if_ready_o(if_ready64),
    .pc_i(pc64), .instr_i(instr64), .rs1_idx_o(rs1_idx64), .rs2_idx_o(rs2_idx64),
    .rs1_en_o(rs1_en64), .rs2_en_o(rs2_en64), .rs1_rdata_i(rs1d64), .rs2_rdata_i(rs2d64),
    .dec_valid_o(dec_valid64), .dec_ready_i(rdy64), .dec_pc_o(dec_pc64),
    .dec_instr_o(dec_instr64), .dec_rs1_rdata_o(dec_rs1_64), .dec_rs2_rdata_o(dec_rs2_64),
    .dec_imm_o(dec_imm64), .dec_rd_idx_o(dec_rd64), .dec_rd_en_o(dec_rd_en64),
    .dec_illegal_o(dec_ill64), .instr_cnt_o(icnt64), .stall_cnt_o(scnt64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; if_valid = 1'b0; dec_ready = 1'b1;
    pc = '0; instr = 32'h0000_0013; rs1d = '0; rs2d = '0;
    f64 = 1'b0; v64 = 1'b0; rdy64 = 1'b1; pc64 = '0; instr64 = 32'h0000_0013;
    rs1d64 = '0; rs2d64 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Sign-interpret the low 'bits' bits of v
  function automatic longint sx(input longint v, input int bits);
    if (v[bits-1]) return v - (longint'(1) << bits);
    return v;
  endfunction

  task automatic ref_dec(input logic [31:0] w, output bit r1, output bit r2, output bit rd,
                         output bit ill, output bit ld, output longint imm);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12];
    r1 = 0; r2 = 0; rd = 0; ill = 0; imm = 0;
    case (op)
      7'h13, 7'h03, 7'h67: begin r1 = 1; rd = 1; imm = sx(longint'(w[31:20]), 12); end
      7'h33: begin r1 = 1; r2 = 1; rd = 1; end
      7'h23: begin r1 = 1; r2 = 1; imm = sx(longint'({w[31:25], w[11:7]}), 12); end
      7'h63: begin r1 = 1; r2 = 1;
        imm = sx(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
      7'h6f: begin rd = 1; imm = sx(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
      7'h37, 7'h17: begin rd = 1; imm = sx(longint'(w[31:12]), 20) * 4096; end
      7'h0f: ;
      7'h73: begin
        if (f3 == 3'd4) ill = 1;
        else if (f3 == 3'd0) ;
        else if (f3 < 3'd4) begin r1 = 1; rd = 1; end
        else begin rd = 1; imm = longint'(w[19:15]); end
      end
      default: ill = 1;
    endcase
    if (w[1:0] != 2'b11) ill = 1;
    if (ill) begin r1 = 0; r2 = 0; rd = 0; imm = 0; end
    ld = (op == 7'h03) && !ill;
  endtask

  function automatic logic [31:0] gen_instr(input logic [4:0] hint);
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0: w[6:0] = 7'h03;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h67;  3: w[6:0] = 7'h33;
      4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;  6: w[6:0] = 7'h6f;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h0f;  10: w[6:0] = 7'h73; 11: w[6:0] = 7'h03;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) w[19:15] = hint;
    if ($urandom_range(0, 3) == 0) w[24:20] = hint;
    return w;
  endfunction

  task automatic test_reset();
    idle_inputs();
    if_valid = 1'b1; instr = 32'hFFF0_0093; pc = 32'h40;
    rst = 1'b1;
    tick();
    tick();
    n_total++; if (dec_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", dec_valid); else n_pass++;
    n_total++; if ({icnt, scnt} !== 64'd0) $display("FAIL reset_cnt got=%h/%h exp=0/0", icnt, scnt); else n_pass++;
    n_total++; if ({dec_pc, dec_instr, dec_imm} !== 96'd0)
      $display("FAIL reset_data got=%h %h %h exp=0", dec_pc, dec_instr, dec_imm); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_addi();
    apply_reset();
    if_valid = 1'b1; instr = 32'hFFF0_0093; pc = 32'h100; rs1d = 32'h11; dec_ready = 1'b1;
    #1;
    n_total++; if ({rs1_en, rs2_en, if_ready} !== 3'b101)
      $display("FAIL addi_en got=%b exp=101", {rs1_en, rs2_en, if_ready}); else n_pass++;
    tick();
    if_valid = 1'b0;
    n_total++; if (dec_valid !== 1'b1) $display("FAIL addi_valid got=%0b exp=1", dec_valid); else n_pass++;
    n_total++; if (dec_imm !== 32'hFFFF_FFFF) $display("FAIL addi_imm got=%h exp=ffffffff", dec_imm); else n_pass++;
    n_total++; if ({dec_rd, dec_rd_en, dec_ill} !== {5'd1, 1'b1, 1'b0})
      $display("FAIL addi_rd got=%0d/%0b/%0b exp=1/1/0", dec_rd, dec_rd_en, dec_ill); else n_pass++;
    n_total++; if ({dec_pc, dec_rs1} !== {32'h100, 32'h11})
      $display("FAIL addi_pc_op got=%h/%h exp=100/11", dec_pc, dec_rs1); else n_pass++;
    tick();
    n_total++; if (icnt !== 32'd1) $display("FAIL addi_icnt got=%0d exp=1", icnt); else n_pass++;
    n_total++; if (dec_valid !== 1'b0) $display("FAIL addi_drain got=%0b exp=0", dec_valid); else n_pass++;
  endtask

  task automatic test_store_csr();
    apply_reset();
    if_valid = 1'b1; instr = 32'h0020_A423; dec_ready = 1'b1;
    #1;
    n_total++; if ({rs1_en, rs2_en, rs1_idx, rs2_idx} !== {2'b11, 5'd1, 5'd2})
      $display("FAIL sw_en got=%b%b %0d %0d exp=11 1 2", rs1_en, rs2_en, rs1_idx, rs2_idx); else n_pass++;
    tick();
    instr = 32'h3002_D1F3;
    n_total++; if ({dec_imm, dec_rd_en} !== {32'h8, 1'b0})
      $display("FAIL sw_imm got=%h/%0b exp=8/0", dec_imm, dec_rd_en); else n_pass++;
    #1;
    n_total++; if ({rs1_en, rs2_en} !== 2'b00) $display("FAIL csr_en got=%b exp=00", {rs1_en, rs2_en}); else n_pass++;
    tick();
    if_valid = 1'b0;
    n_total++; if ({dec_imm, dec_rd_en, dec_rd} !== {32'h5, 1'b1, 5'd3})
      $display("FAIL csr_imm got=%h/%0b/%0d exp=5/1/3", dec_imm, dec_rd_en, dec_rd); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    if_valid = 1'b1; instr = 32'h0000_A283; dec_ready = 1'b1;
    tick();
    instr = 32'h0002_8333;
    #1;
    n_total++; if (if_ready !== 1'b0) $display("FAIL lu_stall got=%0b exp=0", if_ready); else n_pass++;
    tick();
    n_total++; if ({dec_valid, scnt, icnt} !== {1'b0, 32'd1, 32'd1})
      $display("FAIL lu_bubble got=%0b/%0d/%0d exp=0/1/1", dec_valid, scnt, icnt); else n_pass++;
    #1;
    n_total++; if (if_ready !== 1'b1) $display("FAIL lu_release got=%0b exp=1", if_ready); else n_pass++;
    tick();
    n_total++; if ({dec_valid, dec_instr, scnt} !== {1'b1, 32'h0002_8333, 32'd1})
      $display("FAIL lu_accept got=%0b/%h/%0d exp=1/00028333/1", dec_valid, dec_instr, scnt); else n_pass++;
    instr = 32'h0000_A003;
    tick();
    instr = 32'h0000_0333;
    #1;
    n_total++; if (if_ready !== 1'b1) $display("FAIL lu_x0_ready got=%0b exp=1", if_ready); else n_pass++;
    tick();
    if_valid = 1'b0;
    n_total++; if ({dec_instr, scnt} !== {32'h0000_0333, 32'd1})
      $display("FAIL lu_x0 got=%h/%0d exp=00000333/1", dec_instr, scnt); else n_pass++;
    tick();
  endtask

  task automatic test_xlen64();
    apply_reset();
    v64 = 1'b1; instr64 = 32'h8000_00B7; rdy64 = 1'b1;
    tick();
    instr64 = 32'h0000_0000;
    n_total++; if ({dec_valid64, dec_imm64} !== {1'b1, 64'hFFFF_FFFF_8000_0000})
      $display("FAIL x64_lui got=%0b/%h exp=1/ffffffff80000000", dec_valid64, dec_imm64); else n_pass++;
    #1;
    n_total++; if ({rs1_en64, rs2_en64} !== 2'b00)
      $display("FAIL x64_ill_en got=%b exp=00", {rs1_en64, rs2_en64}); else n_pass++;
    tick();
    v64 = 1'b0;
    n_total++; if ({dec_valid64, dec_ill64, dec_rd_en64, dec_imm64} !== {3'b110, 64'd0})
      $display("FAIL x64_ill got=%b/%h exp=110/0", {dec_valid64, dec_ill64, dec_rd_en64}, dec_imm64); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    if_valid = 1'b1; instr = 32'hFFF0_0093; dec_ready = 1'b0; pc = 32'h200;
    tick();
    instr = 32'h0020_0113; pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (if_ready !== 1'b0) $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, if_ready); else n_pass++;
      tick();
      n_total++; if ({dec_valid, dec_instr, dec_pc} !== {1'b1, 32'hFFF0_0093, 32'h200})
        $display("FAIL bp_hold cyc=%0d got=%0b/%h/%h exp=1/fff00093/200", i, dec_valid, dec_instr, dec_pc);
      else n_pass++;
    end
    dec_ready = 1'b1;
    tick();
    n_total++; if ({dec_instr, icnt} !== {32'h0020_0113, 32'd1})
      $display("FAIL b2b_1 got=%h/%0d exp=00200113/1", dec_instr, icnt); else n_pass++;
    instr = 32'h0030_0193; pc = 32'h208;
    tick();
    if_valid = 1'b0;
    n_total++; if ({dec_instr, icnt} !== {32'h0030_0193, 32'd2})
      $display("FAIL b2b_2 got=%h/%0d exp=00300193/2", dec_instr, icnt); else n_pass++;
    tick();
    n_total++; if ({dec_valid, icnt} !== {1'b0, 32'd3})
      $display("FAIL b2b_3 got=%0b/%0d exp=0/3", dec_valid, icnt); else n_pass++;
  endtask

  task automatic test_flush_reset();
    apply_reset();
    if_valid = 1'b1; instr = 32'hFFF0_0093; dec_ready = 1'b0;
    tick();
    instr = 32'h0020_0113; flush = 1'b1;
    tick();
    n_total++; if ({dec_valid, dec_instr, icnt} !== {1'b0, 32'hFFF0_0093, 32'd0})
      $display("FAIL flush_1 got=%0b/%h/%0d exp=0/fff00093/0", dec_valid, dec_instr, icnt); else n_pass++;
    flush = 1'b0; dec_ready = 1'b1;
    tick();
    instr = 32'h0030_0193; flush = 1'b1;
    tick();
    n_total++; if ({dec_valid, dec_instr, icnt} !== {1'b0, 32'h0020_0113, 32'd1})
      $display("FAIL flush_2 got=%0b/%h/%0d exp=0/00200113/1", dec_valid, dec_instr, icnt); else n_pass++;
    flush = 1'b0; instr = 32'hFFF0_0093; pc = 32'h300;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; if_valid = 1'b0;
    n_total++; if ({dec_valid, icnt, scnt, dec_pc, dec_instr, dec_imm} !== {1'b0, 160'd0})
      $display("FAIL midrst got=%0b/%0d/%0d/%h/%h/%h exp=all 0", dec_valid, icnt, scnt, dec_pc, dec_instr, dec_imm);
    else n_pass++;
  endtask

  task automatic test_random();
    bit r1, r2, rde, ill, ld, hz, rdy, acc;
    longint imm;
    bit mv, mld, mrde, mill;
    logic [31:0] mpc, minstr, mrs1, mrs2, mimm, mic, msc;
    logic [4:0] mrd;
    apply_reset();
    mv = 0; mld = 0; mrde = 0; mill = 0; mpc = 0; minstr = 0; mrs1 = 0; mrs2 = 0;
    mimm = 0; mic = 0; msc = 0; mrd = 0;
    for (int c = 0; c < 400; c++) begin
      if_valid  = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      instr = gen_instr(mrd);
      pc = $urandom; rs1d = $urandom; rs2d = $urandom;
      #1;
      ref_dec(instr, r1, r2, rde, ill, ld, imm);
      hz  = mv && mld && (mrd != 0) && ((r1 && instr[19:15] == mrd) || (r2 && instr[24:20] == mrd));
      rdy = (!mv || dec_ready) && !hz;
      n_total++; if (if_ready !== rdy) $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, if_ready, rdy); else n_pass++;
      n_total++; if ({rs1_en, rs2_en, rs1_idx, rs2_idx} !== {r1, r2, instr[19:15], instr[24:20]})
        $display("FAIL rnd_rf c=%0d instr=%h got=%b%b %0d %0d exp=%b%b", c, instr, rs1_en, rs2_en,
                 rs1_idx, rs2_idx, r1, r2); else n_pass++;
      if (mv && dec_ready) mic++;
      if (if_valid && hz && !flush) msc++;
      acc = if_valid && rdy && !flush;
      if (flush) mv = 0;
      else if (acc) begin
        mv = 1; mpc = pc; minstr = instr; mrs1 = rs1d; mrs2 = rs2d; mimm = imm[31:0];
        mrd = instr[11:7]; mrde = rde; mill = ill; mld = ld;
      end else if (dec_ready) mv = 0;
      tick();
      n_total++; if (dec_valid !== mv) $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, dec_valid, mv); else n_pass++;
      n_total++; if ({dec_pc, dec_instr, dec_rs1, dec_rs2} !== {mpc, minstr, mrs1, mrs2})
        $display("FAIL rnd_data c=%0d got=%h %h exp=%h %h", c, dec_pc, dec_instr, mpc, minstr); else n_pass++;
      n_total++; if ({dec_imm, dec_rd, dec_rd_en, dec_ill} !== {mimm, mrd, mrde, mill})
        $display("FAIL rnd_ctrl c=%0d instr=%h got=%h/%0d/%0b/%0b exp=%h/%0d/%0b/%0b", c, dec_instr,
                 dec_imm, dec_rd, dec_rd_en, dec_ill, mimm, mrd, mrde, mill); else n_pass++;
      n_total++; if ({icnt, scnt} !== {mic, msc})
        $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, icnt, scnt, mic, msc); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_addi();
    test_store_csr();
    test_load_use();
    test_xlen64();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
